// File: rtl/egypt_mult_sched_if.sv
// Handshake bundle for egypt_mult_sched: two requesters,
// one response channel and the busy flag.
interface egypt_mult_sched_if #(
  parameter int W = 16
);
  logic           req0_valid;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           req0_ready;
  logic           req1_valid;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           req1_ready;
  logic           rsp_valid;
  logic [2*W-1:0] rsp_d;
  logic           rsp_id;
  logic           rsp_ready;
  logic           busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_d, rsp_id,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_d, rsp_id,
    input  rsp_ready,
    output busy
  );
endinterface

// File: rtl/egypt_mult_sched.sv
// Two-requester round-robin scheduler feeding a shift-add
// (doubling/halving) unsigned multiplier.
module egypt_mult_sched #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  egypt_mult_sched_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] x_q, x_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   y_sh;
  logic           id_q, id_d;
  logic           last_q, last_d;
  logic           gnt;
  logic           any_v;
  logic           rdy0, rdy1;

  assign any_v = bus.req0_valid | bus.req1_valid;
  assign y_sh  = y_q >> 1;

  // on contention the requester not granted last wins
  always_comb begin
    gnt = 1'b0;
    case (1'b1)
      (bus.req0_valid & bus.req1_valid): gnt = ~last_q;
      bus.req1_valid:                     gnt = 1'b1;
      default:                            gnt = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    id_d    = id_q;
    last_d  = last_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_v && !rst) begin
          rdy0   = ~gnt;
          rdy1   = gnt;
          x_d    = {{W{1'b0}}, gnt ? bus.req1_a : bus.req0_a};
          y_d    = gnt ? bus.req1_b : bus.req0_b;
          acc_d  = '0;
          id_d   = gnt;
          last_d = gnt;
          state_d = (y_d != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_sh;
        if (y_sh == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_d      = acc_q;
  assign bus.rsp_id     = id_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
